bitwise_unit: RTL and testbench

Registered, parametrised bitwise/logic unit and the sequential successor to the lab1 per-operation combinational bitwise modules. It takes one operation per accepted valid/ready transfer and produces a registered result one cycle later. It adds extended ops (AND-NOT, OR-NOT, reductions, popcount), an accumulator mode that chains results, and an illegal-opcode flag. It sits beside the arithmetic/shift units under the lab1 ALU top and is selected by the same function-code field.

---
 rtl/bitwise_unit_if.sv | 29 ++
 rtl/bitwise_unit.sv | 150 +++++++++++++++
 tb/tb_bitwise_unit.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bitwise_unit_if.sv
// Request/response bundle for bitwise_unit: operand offer, result handshake
// and accumulator observation. The requester side is master, the unit is slave.
interface bitwise_unit_if #(
  parameter int DATA_WIDTH = 16,
  parameter int FUNC_WIDTH = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [FUNC_WIDTH-1:0] in_func;
  logic                  in_acc;
  logic [DATA_WIDTH-1:0] in_a;
  logic [DATA_WIDTH-1:0] in_b;
  logic                  acc_clear;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_result;
  logic                  out_err;
  logic [DATA_WIDTH-1:0] acc_value;

  modport master (
    output in_valid, in_func, in_acc, in_a, in_b, acc_clear, out_ready,
    input  in_ready, out_valid, out_result, out_err, acc_value
  );

  modport slave (
    input  in_valid, in_func, in_acc, in_a, in_b, acc_clear, out_ready,
    output in_ready, out_valid, out_result, out_err, acc_value
  );
endinterface

// File: rtl/bitwise_unit.sv
// Registered bitwise/logic unit with accumulator chaining, reductions,
// popcount and an illegal-opcode flag; one op per valid/ready transfer.
module bitwise_unit #(
  parameter int DATA_WIDTH = 16,
  parameter int FUNC_WIDTH = 4
) (
  input logic           clk,
  input logic           reset,
  bitwise_unit_if.slave bus
);

  typedef enum logic [3:0] {
    OP_NOT    = 4'd0,
    OP_AND    = 4'd1,
    OP_OR     = 4'd2,
    OP_NAND   = 4'd3,
    OP_NOR    = 4'd4,
    OP_XOR    = 4'd5,
    OP_XNOR   = 4'd6,
    OP_PASS   = 4'd7,
    OP_ANDN   = 4'd8,
    OP_ORN    = 4'd9,
    OP_RAND   = 4'd10,
    OP_ROR    = 4'd11,
    OP_RXOR   = 4'd12,
    OP_POPCNT = 4'd13
  } op_e;

  // Count never exceeds DATA_WIDTH, which fits in DATA_WIDTH bits for widths >= 2.
  function automatic logic [DATA_WIDTH-1:0] popcount(input logic [DATA_WIDTH-1:0] v);
    logic [DATA_WIDTH-1:0] c;
    c = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      c = c + DATA_WIDTH'(v[i]);
    end
    return c;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] bit0(input logic b);
    return {{(DATA_WIDTH-1){1'b0}}, b};
  endfunction

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_result_q, out_result_d;
  logic                  out_err_q, out_err_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;

  logic                  in_ready_s;
  logic                  accept_s;
  logic                  consume_s;
  op_e                   op_s;
  logic [DATA_WIDTH-1:0] acc_seen_s;
  logic [DATA_WIDTH-1:0] a_eff_s;
  logic [DATA_WIDTH-1:0] result_s;
  logic                  err_s;

  assign in_ready_s = !out_valid_q || bus.out_ready;
  assign accept_s   = bus.in_valid && in_ready_s;
  assign consume_s  = out_valid_q && bus.out_ready;
  assign op_s       = op_e'(bus.in_func[3:0]);

  // Operand selection; a same-cycle clear makes acc-mode ops see zero.
  always_comb begin
    acc_seen_s = acc_q;
    a_eff_s    = bus.in_a;
    if (bus.acc_clear) begin
      acc_seen_s = '0;
    end else begin
      acc_seen_s = acc_q;
    end
    if (bus.in_acc) begin
      a_eff_s = acc_seen_s;
    end else begin
      a_eff_s = bus.in_a;
    end
  end

  // Opcode decode; 14 and 15 fall to the illegal default.
  always_comb begin
    result_s = '0;
    err_s    = 1'b0;
    case (op_s)
      OP_NOT:    result_s = ~a_eff_s;
      OP_AND:    result_s = a_eff_s & bus.in_b;
      OP_OR:     result_s = a_eff_s | bus.in_b;
      OP_NAND:   result_s = ~(a_eff_s & bus.in_b);
      OP_NOR:    result_s = ~(a_eff_s | bus.in_b);
      OP_XOR:    result_s = a_eff_s ^ bus.in_b;
      OP_XNOR:   result_s = ~(a_eff_s ^ bus.in_b);
      OP_PASS:   result_s = a_eff_s;
      OP_ANDN:   result_s = a_eff_s & ~bus.in_b;
      OP_ORN:    result_s = a_eff_s | ~bus.in_b;
      OP_RAND:   result_s = bit0(&a_eff_s);
      OP_ROR:    result_s = bit0(|a_eff_s);
      OP_RXOR:   result_s = bit0(^a_eff_s);
      OP_POPCNT: result_s = popcount(a_eff_s);
      default: begin
        result_s = '0;
        err_s    = 1'b1;
      end
    endcase
  end

  // Next state: an accept overrides both consume and clear.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_err_d    = out_err_q;
    acc_d        = acc_q;
    if (accept_s) begin
      out_valid_d  = 1'b1;
      out_result_d = result_s;
      out_err_d    = err_s;
      acc_d        = result_s;
    end else begin
      if (consume_s) begin
        out_valid_d = 1'b0;
      end else begin
        out_valid_d = out_valid_q;
      end
      if (bus.acc_clear) begin
        acc_d = '0;
      end else begin
        acc_d = acc_q;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_err_q    <= 1'b0;
      acc_q        <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_err_q    <= out_err_d;
      acc_q        <= acc_d;
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_err    = out_err_q;
  assign bus.acc_value  = acc_q;

endmodule

// File: tb/tb_bitwise_unit.sv
// Self-checking bench for bitwise_unit: directed scenarios on a 16-bit unit,
// then a randomized stream on 16-bit and 5-bit units against a behavioural model.
module tb_bitwise_unit;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  bitwise_unit_if #(.DATA_WIDTH(16), .FUNC_WIDTH(4)) b16 ();
  bitwise_unit_if #(.DATA_WIDTH(5),  .FUNC_WIDTH(4)) b5 ();

  bitwise_unit #(.DATA_WIDTH(16), .FUNC_WIDTH(4)) u16 (.clk(clk), .reset(reset), .bus(b16));
  bitwise_unit #(.DATA_WIDTH(5),  .FUNC_WIDTH(4)) u5  (.clk(clk), .reset(reset), .bus(b5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {err, result} for a width w, straight from the opcode table.
  function automatic logic [64:0] ref_op(input int w, input logic [3:0] f,
                                         input logic [63:0] a_in, input logic [63:0] b_in);
    logic [63:0] mask, a, b, r;
    logic        e;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    a = a_in & mask;
    b = b_in & mask;
    e = 1'b0;
    case (f)
      4'd0:    r = ~a;
      4'd1:    r = a & b;
      4'd2:    r = a | b;
      4'd3:    r = ~(a & b);
      4'd4:    r = ~(a | b);
      4'd5:    r = a ^ b;
      4'd6:    r = ~(a ^ b);
      4'd7:    r = a;
      4'd8:    r = a & ~b;
      4'd9:    r = a | ~b;
      4'd10:   r = (a == mask) ? 64'd1 : 64'd0;
      4'd11:   r = (a != 64'd0) ? 64'd1 : 64'd0;
      4'd12:   r = ($countones(a) % 2 == 1) ? 64'd1 : 64'd0;
      4'd13:   r = 64'($countones(a));
      default: begin r = 64'd0; e = 1'b1; end
    endcase
    return {e, r & mask};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    b16.in_valid = 1'b0; b16.in_func = 4'd0; b16.in_acc = 1'b0;
    b16.in_a = 16'd0; b16.in_b = 16'd0; b16.acc_clear = 1'b0; b16.out_ready = 1'b1;
    b5.in_valid = 1'b0; b5.in_func = 4'd0; b5.in_acc = 1'b0;
    b5.in_a = 5'd0; b5.in_b = 5'd0; b5.acc_clear = 1'b0; b5.out_ready = 1'b1;
  endtask

  task automatic op16(input logic [3:0] f, input logic acc, input logic [15:0] a,
                      input logic [15:0] b, input logic clr);
    b16.in_valid = 1'b1; b16.in_func = f; b16.in_acc = acc;
    b16.in_a = a; b16.in_b = b; b16.acc_clear = clr;
  endtask

  task automatic test_reset();
    idle_inputs();
    b16.out_ready = 1'b0;
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    n_tests += 5;
    if (b16.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b expected 0", b16.out_valid); end
    if (b16.out_result !== 16'h0000) begin n_fail++; $display("FAIL reset out_result: got %h expected 0000", b16.out_result); end
    if (b16.out_err !== 1'b0) begin n_fail++; $display("FAIL reset out_err: got %b expected 0", b16.out_err); end
    if (b16.acc_value !== 16'h0000) begin n_fail++; $display("FAIL reset acc_value: got %h expected 0000", b16.acc_value); end
    if (b16.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready: got %b expected 1", b16.in_ready); end
    b16.out_ready = 1'b1;
  endtask

  task automatic test_first_op();
    op16(4'd1, 1'b0, 16'hF0F0, 16'hFF00, 1'b0);
    cyc();
    b16.in_valid = 1'b0;
    n_tests += 4;
    if (b16.out_result !== 16'hF000) begin n_fail++; $display("FAIL first result: got %h expected f000", b16.out_result); end
    if (b16.out_valid !== 1'b1) begin n_fail++; $display("FAIL first out_valid: got %b expected 1", b16.out_valid); end
    if (b16.out_err !== 1'b0) begin n_fail++; $display("FAIL first out_err: got %b expected 0", b16.out_err); end
    if (b16.acc_value !== 16'hF000) begin n_fail++; $display("FAIL first acc_value: got %h expected f000", b16.acc_value); end
  endtask

  task automatic test_opcode_sweep();
    logic [15:0] exp_r [16];
    exp_r = '{16'h5A3C, 16'h05C0, 16'hAFF3, 16'hFA3F, 16'h500C, 16'hAA33, 16'h55CC, 16'hA5C3,
              16'hA003, 16'hF5CF, 16'h0000, 16'h0001, 16'h0000, 16'h0008, 16'h0000, 16'h0000};
    for (int f = 0; f < 16; f++) begin
      op16(4'(f), 1'b0, 16'hA5C3, 16'h0FF0, 1'b0);
      cyc();
      n_tests += 3;
      if (b16.out_result !== exp_r[f]) begin n_fail++; $display("FAIL sweep op%0d result: got %h expected %h", f, b16.out_result, exp_r[f]); end
      if (b16.out_err !== (f >= 14)) begin n_fail++; $display("FAIL sweep op%0d err: got %b expected %b", f, b16.out_err, (f >= 14)); end
      if (b16.acc_value !== exp_r[f]) begin n_fail++; $display("FAIL sweep op%0d acc: got %h expected %h", f, b16.acc_value, exp_r[f]); end
    end
    b16.in_valid = 1'b0;
  endtask

  task automatic test_acc_chain();
    op16(4'd7, 1'b0, 16'h00FF, 16'h0000, 1'b0);
    cyc();
    op16(4'd2, 1'b1, 16'hDEAD, 16'h0F00, 1'b0);
    n_tests += 1;
    if (b16.out_result !== 16'h00FF) begin n_fail++; $display("FAIL chain op1: got %h expected 00ff", b16.out_result); end
    cyc();
    op16(4'd5, 1'b1, 16'hBEEF, 16'hFFFF, 1'b0);
    n_tests += 1;
    if (b16.out_result !== 16'h0FFF) begin n_fail++; $display("FAIL chain op2: got %h expected 0fff", b16.out_result); end
    cyc();
    b16.in_valid = 1'b0;
    b16.acc_clear = 1'b1;
    n_tests += 2;
    if (b16.out_result !== 16'hF000) begin n_fail++; $display("FAIL chain op3: got %h expected f000", b16.out_result); end
    if (b16.acc_value !== 16'hF000) begin n_fail++; $display("FAIL chain acc3: got %h expected f000", b16.acc_value); end
    cyc();
    b16.acc_clear = 1'b0;
    n_tests += 2;
    if (b16.acc_value !== 16'h0000) begin n_fail++; $display("FAIL chain clear acc: got %h expected 0000", b16.acc_value); end
    if (b16.out_result !== 16'hF000) begin n_fail++; $display("FAIL chain clear result: got %h expected f000", b16.out_result); end
  endtask

  task automatic test_clear_collision();
    op16(4'd7, 1'b0, 16'h1234, 16'h0000, 1'b0);
    cyc();
    n_tests += 1;
    if (b16.acc_value !== 16'h1234) begin n_fail++; $display("FAIL collision setup acc: got %h expected 1234", b16.acc_value); end
    op16(4'd2, 1'b1, 16'hFFFF, 16'h0001, 1'b1);
    cyc();
    b16.in_valid = 1'b0;
    b16.acc_clear = 1'b0;
    n_tests += 2;
    if (b16.out_result !== 16'h0001) begin n_fail++; $display("FAIL collision result: got %h expected 0001", b16.out_result); end
    if (b16.acc_value !== 16'h0001) begin n_fail++; $display("FAIL collision acc: got %h expected 0001", b16.acc_value); end
  endtask

  task automatic test_back_to_back_backpressure();
    op16(4'd7, 1'b0, 16'hBEEF, 16'h0000, 1'b0);
    cyc();
    op16(4'd7, 1'b0, 16'hCAFE, 16'h0000, 1'b0);
    b16.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_tests += 4;
      if (b16.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp in_ready c%0d: got %b expected 0", i, b16.in_ready); end
      if (b16.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp out_valid c%0d: got %b expected 1", i, b16.out_valid); end
      if (b16.out_result !== 16'hBEEF) begin n_fail++; $display("FAIL bp result c%0d: got %h expected beef", i, b16.out_result); end
      if (b16.acc_value !== 16'hBEEF) begin n_fail++; $display("FAIL bp acc c%0d: got %h expected beef", i, b16.acc_value); end
    end
    b16.out_ready = 1'b1;
    #1;
    n_tests += 1;
    if (b16.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp release in_ready: got %b expected 1", b16.in_ready); end
    cyc();
    b16.in_valid = 1'b0;
    n_tests += 2;
    if (b16.out_result !== 16'hCAFE) begin n_fail++; $display("FAIL bp queued result: got %h expected cafe", b16.out_result); end
    if (b16.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp queued valid: got %b expected 1", b16.out_valid); end
    cyc();
    n_tests += 2;
    if (b16.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp drained valid: got %b expected 0", b16.out_valid); end
    if (b16.out_result !== 16'hCAFE) begin n_fail++; $display("FAIL bp drained hold: got %h expected cafe", b16.out_result); end
  endtask

  task automatic test_reset_midstream();
    b16.out_ready = 1'b0; b5.out_ready = 1'b0;
    op16(4'd0, 1'b0, 16'h1111, 16'h0000, 1'b0);
    b5.in_valid = 1'b1; b5.in_func = 4'd0; b5.in_a = 5'h03;
    cyc();
    b16.in_a = 16'h2222; b5.in_a = 5'h0C;
    b16.out_ready = 1'b1; b5.out_ready = 1'b1;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    idle_inputs();
    n_tests += 10;
    if (b16.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst16 out_valid: got %b expected 0", b16.out_valid); end
    if (b16.out_result !== 16'h0000) begin n_fail++; $display("FAIL midrst16 result: got %h expected 0000", b16.out_result); end
    if (b16.out_err !== 1'b0) begin n_fail++; $display("FAIL midrst16 err: got %b expected 0", b16.out_err); end
    if (b16.acc_value !== 16'h0000) begin n_fail++; $display("FAIL midrst16 acc: got %h expected 0000", b16.acc_value); end
    if (b16.in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst16 in_ready: got %b expected 1", b16.in_ready); end
    if (b5.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst5 out_valid: got %b expected 0", b5.out_valid); end
    if (b5.out_result !== 5'h00) begin n_fail++; $display("FAIL midrst5 result: got %h expected 00", b5.out_result); end
    if (b5.out_err !== 1'b0) begin n_fail++; $display("FAIL midrst5 err: got %b expected 0", b5.out_err); end
    if (b5.acc_value !== 5'h00) begin n_fail++; $display("FAIL midrst5 acc: got %h expected 00", b5.acc_value); end
    if (b5.in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst5 in_ready: got %b expected 1", b5.in_ready); end
  endtask

  // Both widths run the same kind of random traffic; index 0 is 16-bit, 1 is 5-bit.
  task automatic test_random_stream();
    logic [63:0] m_res [2], m_acc [2], aeff;
    logic        m_err [2], m_valid [2];
    logic        v [2], ac [2], clr [2], ordy [2], rdy;
    logic [3:0]  f [2];
    logic [63:0] a [2], b [2];
    logic [64:0] rr;
    logic [63:0] o_res [2], o_acc [2];
    logic        o_err [2], o_valid [2], o_rdy [2];
    int          w [2];
    w[0] = 16; w[1] = 5;
    for (int k = 0; k < 2; k++) begin
      m_res[k] = 64'd0; m_acc[k] = 64'd0; m_err[k] = 1'b0; m_valid[k] = 1'b0;
    end
    for (int n = 0; n < 1000; n++) begin
      for (int k = 0; k < 2; k++) begin
        v[k]    = ($urandom_range(3, 0) != 0);
        f[k]    = 4'($urandom_range(15, 0));
        ac[k]   = ($urandom_range(1, 0) == 1);
        clr[k]  = ($urandom_range(7, 0) == 0);
        ordy[k] = ($urandom_range(3, 0) != 0);
        a[k]    = {$urandom, $urandom};
        b[k]    = {$urandom, $urandom};
      end
      b16.in_valid = v[0]; b16.in_func = f[0]; b16.in_acc = ac[0]; b16.acc_clear = clr[0];
      b16.out_ready = ordy[0]; b16.in_a = a[0][15:0]; b16.in_b = b[0][15:0];
      b5.in_valid = v[1]; b5.in_func = f[1]; b5.in_acc = ac[1]; b5.acc_clear = clr[1];
      b5.out_ready = ordy[1]; b5.in_a = a[1][4:0]; b5.in_b = b[1][4:0];
      #1;
      o_rdy[0] = b16.in_ready; o_rdy[1] = b5.in_ready;
      for (int k = 0; k < 2; k++) begin
        rdy = !m_valid[k] || ordy[k];
        n_tests++;
        if (o_rdy[k] !== rdy) begin n_fail++; $display("FAIL rand w%0d n%0d in_ready: got %b expected %b", w[k], n, o_rdy[k], rdy); end
        if (v[k] && rdy) begin
          aeff = ac[k] ? (clr[k] ? 64'd0 : m_acc[k]) : a[k];
          rr = ref_op(w[k], f[k], aeff, b[k]);
          m_res[k] = rr[63:0]; m_err[k] = rr[64]; m_valid[k] = 1'b1; m_acc[k] = rr[63:0];
        end else begin
          if (m_valid[k] && ordy[k]) m_valid[k] = 1'b0;
          if (clr[k]) m_acc[k] = 64'd0;
        end
      end
      cyc();
      o_res[0] = 64'(b16.out_result); o_acc[0] = 64'(b16.acc_value);
      o_err[0] = b16.out_err; o_valid[0] = b16.out_valid;
      o_res[1] = 64'(b5.out_result); o_acc[1] = 64'(b5.acc_value);
      o_err[1] = b5.out_err; o_valid[1] = b5.out_valid;
      for (int k = 0; k < 2; k++) begin
        n_tests += 4;
        if (o_valid[k] !== m_valid[k]) begin n_fail++; $display("FAIL rand w%0d n%0d out_valid: got %b expected %b", w[k], n, o_valid[k], m_valid[k]); end
        if (o_res[k] !== m_res[k]) begin n_fail++; $display("FAIL rand w%0d n%0d result: got %h expected %h", w[k], n, o_res[k], m_res[k]); end
        if (o_err[k] !== m_err[k]) begin n_fail++; $display("FAIL rand w%0d n%0d err: got %b expected %b", w[k], n, o_err[k], m_err[k]); end
        if (o_acc[k] !== m_acc[k]) begin n_fail++; $display("FAIL rand w%0d n%0d acc: got %h expected %h", w[k], n, o_acc[k], m_acc[k]); end
      end
    end
    idle_inputs();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    idle_inputs();
    test_reset();
    test_first_op();
    test_opcode_sweep();
    test_acc_chain();
    test_clear_collision();
    test_back_to_back_backpressure();
    test_reset_midstream();
    test_random_stream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
